// File: rtl/alu_arbiter_v1.sv
// alu_arbiter_v1: two requesters share one registered alu_v1 through an IDLE/EXEC/RESP handshake FSM.
// alu_v1 is the combinational ALU core; illegal opcodes (>9) yield a fixed F7F7F7F7 pattern.
module alu_v1 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [31:0] out_o,
    output logic        zero_flag_o,
    output logic        sign_flag_o,
    output logic [7:0]  error_vector_o
);
    logic [31:0] sum, diff;
    assign sum = a_i + b_i;
    assign diff = a_i - b_i;
    always_comb begin
        out_o = 32'hF7F7F7F7;
        error_vector_o = '0;
        case (op_i)
            4'd0: begin
                out_o = sum;
                error_vector_o[0] = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            4'd1: begin
                out_o = diff;
                error_vector_o[1] = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            4'd2: out_o = a_i & b_i;
            4'd3: out_o = a_i | b_i;
            4'd4: out_o = a_i ^ b_i;
            4'd5: out_o = a_i << b_i[4:0];
            4'd6: out_o = a_i >> b_i[4:0];
            4'd7: out_o = $signed(a_i) >>> b_i[4:0];
            4'd8: out_o = {31'b0, $signed(a_i) < $signed(b_i)};
            4'd9: out_o = {31'b0, a_i < b_i};
            default: ;
        endcase
    end
    assign zero_flag_o = out_o == 32'd0;
    assign sign_flag_o = out_o[31];
endmodule

module alu_arbiter_v1 #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op_code,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op_code,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero_flag,
    output logic        rsp_sign_flag,
    output logic [7:0]  rsp_error_vector,
    output logic        rsp_illegal,
    output logic [15:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, a_d, b_d, alu_out;
    logic [3:0]  op_q, op_d;
    logic        last_grant_q, grant1, accept, alu_zero, alu_sign;
    logic [7:0]  alu_err;
    logic        rsp_id_q, rsp_zero_q, rsp_sign_q, rsp_illegal_q;
    logic [31:0] rsp_out_q;
    logic [7:0]  rsp_err_q;
    logic [15:0] ops_done_q;

    alu_v1 u_alu (
        .a_i(a_q), .b_i(b_q), .op_i(op_q),
        .out_o(alu_out), .zero_flag_o(alu_zero), .sign_flag_o(alu_sign), .error_vector_o(alu_err)
    );

    // Requester 1 wins when alone, or on a round-robin tie when requester 0 went last.
    assign grant1 = req1_valid && (!req0_valid || (PRIO_MODE == 0 && !last_grant_q));
    assign req1_ready = state_q == IDLE && grant1;
    assign req0_ready = state_q == IDLE && req0_valid && !grant1;
    assign accept = req0_ready || req1_ready;
    assign a_d = req1_ready ? req1_a : req0_a;
    assign b_d = req1_ready ? req1_b : req0_b;
    assign op_d = req1_ready ? req1_op_code : req0_op_code;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            last_grant_q  <= 1'b1;
            rsp_id_q      <= 1'b0;
            rsp_out_q     <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_sign_q    <= 1'b0;
            rsp_err_q     <= '0;
            rsp_illegal_q <= 1'b0;
            ops_done_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q          <= a_d;
                b_q          <= b_d;
                op_q         <= op_d;
                last_grant_q <= req1_ready;
            end
            if (state_q == EXEC) begin
                rsp_id_q      <= last_grant_q;
                rsp_out_q     <= alu_out;
                rsp_zero_q    <= alu_zero;
                rsp_sign_q    <= alu_sign;
                rsp_err_q     <= alu_err;
                rsp_illegal_q <= op_q > 4'b1001;
            end
            if (state_q == RESP && rsp_ready)
                ops_done_q <= ops_done_q + 16'd1;
        end
    end

    assign rsp_valid = state_q == RESP;
    assign rsp_id = rsp_id_q;
    assign rsp_out = rsp_out_q;
    assign rsp_zero_flag = rsp_zero_q;
    assign rsp_sign_flag = rsp_sign_q;
    assign rsp_error_vector = rsp_err_q;
    assign rsp_illegal = rsp_illegal_q;
    assign ops_done = ops_done_q;
endmodule

// File: tb/tb_alu_arbiter_v1.sv
// tb_alu_arbiter_v1: directed checks of arbitration, latency, backpressure, illegal ops and reset.
// Two instances share stimulus: dut (round-robin) and dut_p (fixed priority).
module tb_alu_arbiter_v1;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op_code = '0, req1_op_code = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero_flag, rsp_sign_flag, rsp_illegal;
    logic [31:0] rsp_out;
    logic [7:0]  rsp_error_vector;
    logic [15:0] ops_done;
    logic        p_req0_ready, p_req1_ready, p_rsp_valid, p_rsp_id, p_zero, p_sign, p_illegal;
    logic [31:0] p_rsp_out;
    logic [7:0]  p_err;
    logic [15:0] p_ops_done;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_v1 #(.PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op_code(req0_op_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op_code(req1_op_code),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_zero_flag(rsp_zero_flag), .rsp_sign_flag(rsp_sign_flag), .rsp_error_vector(rsp_error_vector),
        .rsp_illegal(rsp_illegal), .ops_done(ops_done)
    );

    alu_arbiter_v1 #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op_code(req0_op_code),
        .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op_code(req1_op_code),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(p_rsp_id), .rsp_out(p_rsp_out),
        .rsp_zero_flag(p_zero), .rsp_sign_flag(p_sign), .rsp_error_vector(p_err),
        .rsp_illegal(p_illegal), .ops_done(p_ops_done)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end checks++;
        if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got %h exp 0000", ops_done); end checks++;
        if ({rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag, rsp_error_vector, rsp_illegal} !== 44'd0) begin
            errors++; $display("FAIL reset_rsp_regs got %h %h %b %b %h %b exp all zero", rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag, rsp_error_vector, rsp_illegal);
        end checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_idle got %b exp 00", {req0_ready, req1_ready}); end checks++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_tie got %b exp 10", {req0_ready, req1_ready}); end checks++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op_code = 4'd0; rsp_ready = 1'b1;
        #1;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end checks++;
        step();
        req0_valid = 1'b0;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid got %b exp 0", rsp_valid); end checks++;
        step();
        if ({rsp_valid, rsp_id, rsp_zero_flag, rsp_sign_flag} !== 4'b1000) begin
            errors++; $display("FAIL single_flags got %b exp 1000", {rsp_valid, rsp_id, rsp_zero_flag, rsp_sign_flag});
        end checks++;
        if (rsp_out !== 32'd5) begin errors++; $display("FAIL single_out got %h exp 00000005", rsp_out); end checks++;
        step();
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %b exp 0", rsp_valid); end checks++;
        if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done got %0d exp 1", ops_done); end checks++;
    endtask

    task automatic test_round_robin();
        pulse_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_op_code = 4'd1;
        req1_valid = 1'b1; req1_a = 32'hFFFF0000; req1_b = 32'h0000FFFF; req1_op_code = 4'd3;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_grant%0d got %b", k, {req0_ready, req1_ready});
            end checks++;
            step();
            step();
            if (k % 2 == 0) begin
                if ({rsp_valid, rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag} !== {2'b10, 32'h0, 2'b10}) begin
                    errors++; $display("FAIL rr_rsp%0d got v%b id%b %h z%b s%b exp v1 id0 00000000 z1 s0", k, rsp_valid, rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag);
                end checks++;
            end else begin
                if ({rsp_valid, rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag} !== {2'b11, 32'hFFFFFFFF, 2'b01}) begin
                    errors++; $display("FAIL rr_rsp%0d got v%b id%b %h z%b s%b exp v1 id1 ffffffff z0 s1", k, rsp_valid, rsp_id, rsp_out, rsp_zero_flag, rsp_sign_flag);
                end checks++;
            end
            step();
        end
        if (ops_done !== 16'd4) begin errors++; $display("FAIL rr_ops_done got %0d exp 4", ops_done); end checks++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8; req0_op_code = 4'd0;
        #1;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", req0_ready); end checks++;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h0FF00FF0; req1_op_code = 4'd2;
        #1;
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready1 got %b exp 0", req1_ready); end checks++;
        step();
        for (int i = 0; i < 4; i++) begin
            if ({rsp_valid, rsp_id, rsp_out, req1_ready} !== {2'b10, 32'd15, 1'b0}) begin
                errors++; $display("FAIL bp_hold%0d got v%b id%b %h r1%b exp v1 id0 0000000f r1 0", i, rsp_valid, rsp_id, rsp_out, req1_ready);
            end checks++;
            if (i < 3) step();
        end
        rsp_ready = 1'b1;
        step();
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1 got %b exp 1", req1_ready); end checks++;
        if (ops_done !== 16'd5) begin errors++; $display("FAIL bp_ops_done got %0d exp 5", ops_done); end checks++;
        step();
        req1_valid = 1'b0;
        step();
        if ({rsp_valid, rsp_id, rsp_out} !== {2'b11, 32'h0F000F00}) begin
            errors++; $display("FAIL bp_rsp1 got v%b id%b %h exp v1 id1 0f000f00", rsp_valid, rsp_id, rsp_out);
        end checks++;
        step();
    endtask

    task automatic test_illegal();
        logic [3:0]  ops [3] = '{4'b1111, 4'b1001, 4'b1010};
        logic [31:0] exp_out [3] = '{32'hF7F7F7F7, 32'd1, 32'hF7F7F7F7};
        logic        exp_ill [3] = '{1'b1, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op_code = ops[i];
            #1;
            if (req1_ready !== 1'b1) begin errors++; $display("FAIL ill_ready%0d got %b exp 1", i, req1_ready); end checks++;
            step();
            req1_valid = 1'b0;
            step();
            if ({rsp_valid, rsp_id, rsp_out, rsp_illegal, rsp_error_vector, rsp_sign_flag} !== {2'b11, exp_out[i], exp_ill[i], 8'h00, exp_out[i][31]}) begin
                errors++; $display("FAIL ill_rsp%0d got v%b id%b %h ill%b err%h s%b exp %h ill%b", i, rsp_valid, rsp_id, rsp_out, rsp_illegal, rsp_error_vector, rsp_sign_flag, exp_out[i], exp_ill[i]);
            end checks++;
            step();
        end
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h80000000; req0_b = 32'd1; req0_op_code = 4'd7;
        #1;
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        if ({rsp_valid, ops_done} !== 17'd0) begin errors++; $display("FAIL mid_rst_clear got v%b ops%0d exp v0 ops0", rsp_valid, ops_done); end checks++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_rsp%0d got %b exp 0", i, rsp_valid); end checks++;
        end
        req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        if ({rsp_valid, rsp_out, rsp_sign_flag} !== {1'b1, 32'hC0000000, 1'b1}) begin
            errors++; $display("FAIL mid_rst_redo got v%b %h s%b exp v1 c0000000 s1", rsp_valid, rsp_out, rsp_sign_flag);
        end checks++;
        step();
        if (ops_done !== 16'd1) begin errors++; $display("FAIL mid_rst_ops_done got %0d exp 1", ops_done); end checks++;
    endtask

    task automatic test_fixed_priority();
        pulse_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op_code = 4'd0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op_code = 4'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if ({p_req0_ready, p_req1_ready} !== 2'b10) begin errors++; $display("FAIL prio_grant%0d got %b exp 10", k, {p_req0_ready, p_req1_ready}); end checks++;
            step();
            step();
            if ({p_rsp_valid, p_rsp_id, p_rsp_out} !== {2'b10, 32'd2}) begin
                errors++; $display("FAIL prio_rsp%0d got v%b id%b %h exp v1 id0 00000002", k, p_rsp_valid, p_rsp_id, p_rsp_out);
            end checks++;
            step();
        end
        if (p_ops_done !== 16'd3) begin errors++; $display("FAIL prio_ops_done got %0d exp 3", p_ops_done); end checks++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_fixed_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
